// File: rtl/ifmap_row_rx.sv
// ifmap_row_rx: NoC receive endpoint for input-feature-map packets.
// Packets may arrive in any column order; they are assembled into
// ping-pong row buffers and each completed row is streamed out in
// column order with a valid/ready handshake.
module ifmap_row_rx #(
  parameter int         WIDTH_DATA = 13,
  parameter int         WIDTH_I    = 25,
  parameter logic [7:0] NODE_ADDR  = 8'h00,
  parameter logic [1:0] DATA_TYPE  = 2'b01
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pkt_valid,
  output logic                  pkt_ready,
  input  logic [31:0]           pkt_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH_DATA-1:0] out_data,
  output logic [7:0]            out_col,
  output logic                  out_last,
  output logic [7:0]            row_cnt,
  output logic [7:0]            drop_cnt
);

  // Index width for the column address into a bank.
  localparam int         AW       = (WIDTH_I > 1) ? $clog2(WIDTH_I) : 1;
  localparam logic [7:0] LAST_COL = 8'(WIDTH_I - 1);

  // Row storage: two banks, no reset (contents are qualified by the full flags).
  logic [WIDTH_DATA-1:0] r_mem [0:1][0:WIDTH_I-1];

  // Control state.
  logic                    r_wr_bank;
  logic                    r_rd_bank;
  logic [1:0]              r_full;
  logic [1:0][WIDTH_I-1:0] r_bitmap;
  logic [7:0]              r_rd_col;
  logic [7:0]              r_row_cnt;
  logic [7:0]              r_drop_cnt;

  // Packet field decode.
  logic                  w_rsvd;
  logic [1:0]            w_type;
  logic [7:0]            w_dst;
  logic [7:0]            w_col;
  logic [WIDTH_DATA-1:0] w_value;
  logic                  w_col_ok;
  logic                  w_pkt_ok;
  logic                  w_accept;
  logic                  w_wr;
  logic                  w_drop;
  logic [WIDTH_I-1:0]    w_col_mask;
  logic [WIDTH_I-1:0]    w_bitmap_set;
  logic                  w_row_done;
  logic                  w_rd;
  logic                  w_rd_last;
  logic                  w_at_last;

  assign w_rsvd   = pkt_data[31];
  assign w_type   = pkt_data[30:29];
  assign w_dst    = pkt_data[28:21];
  assign w_col    = pkt_data[20:13];
  assign w_value  = pkt_data[WIDTH_DATA-1:0];
  assign w_col_ok = ({1'b0, w_col} < 9'(WIDTH_I));

  assign w_pkt_ok = !w_rsvd && (w_type == DATA_TYPE) && (w_dst == NODE_ADDR) && w_col_ok;
  assign w_accept = pkt_valid && pkt_ready;
  assign w_wr     = w_accept && w_pkt_ok;
  assign w_drop   = w_accept && !w_pkt_ok;

  // One-hot decode of the incoming column, used to update the written bitmap.
  generate
    for (genvar gi = 0; gi < WIDTH_I; gi++) begin : g_col_mask
      assign w_col_mask[gi] = (w_col == 8'(gi));
    end
  endgenerate

  assign w_bitmap_set = r_bitmap[r_wr_bank] | w_col_mask;
  assign w_row_done   = w_wr && (&w_bitmap_set);

  // Read-side handshake.
  assign w_at_last = (r_rd_col == LAST_COL);
  assign w_rd      = out_valid && out_ready;
  assign w_rd_last = w_rd && w_at_last;

  // Ready depends only on registered state: the bank being written must be free.
  assign pkt_ready = !r_full[r_wr_bank];
  assign out_valid = r_full[r_rd_bank];
  assign out_data  = out_valid ? r_mem[r_rd_bank][r_rd_col[AW-1:0]] : '0;
  assign out_col   = out_valid ? r_rd_col : 8'd0;
  assign out_last  = out_valid && w_at_last;
  assign row_cnt   = r_row_cnt;
  assign drop_cnt  = r_drop_cnt;

  // Store the pixel of every valid packet; duplicates simply overwrite.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_bank][w_col[AW-1:0]] <= w_value;
    end
  end

  // Write side: track written columns and flip to the other bank on row completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_bank <= 1'b0;
      r_bitmap  <= '0;
    end else if (w_wr) begin
      if (w_row_done) begin
        r_bitmap[r_wr_bank] <= '0;
        r_wr_bank           <= ~r_wr_bank;
      end else begin
        r_bitmap[r_wr_bank] <= w_bitmap_set;
      end
    end
  end

  // Full flags: set by a completing write, cleared by the last read beat (never the same bank).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_full <= 2'b00;
    end else begin
      if (w_row_done) begin
        r_full[r_wr_bank] <= 1'b1;
      end
      if (w_rd_last) begin
        r_full[r_rd_bank] <= 1'b0;
      end
    end
  end

  // Read side: walk columns in order, release the bank after the last column.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_bank <= 1'b0;
      r_rd_col  <= 8'd0;
      r_row_cnt <= 8'd0;
    end else if (w_rd) begin
      if (w_rd_last) begin
        r_rd_bank <= ~r_rd_bank;
        r_rd_col  <= 8'd0;
        r_row_cnt <= r_row_cnt + 8'd1;
      end else begin
        r_rd_col <= r_rd_col + 8'd1;
      end
    end
  end

  // Count discarded packets, saturating at 255.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_drop_cnt <= 8'd0;
    end else if (w_drop && (r_drop_cnt != 8'hFF)) begin
      r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_ifmap_row_rx.sv
// tb_ifmap_row_rx: directed + randomized bench for ifmap_row_rx with a
// row-level reference model (partial row array, queue of completed pixels).
module tb_ifmap_row_rx;

  localparam int         WD   = 13;
  localparam int         WI   = 25;
  localparam logic [7:0] NODE = 8'h00;
  localparam logic [1:0] DT   = 2'b01;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          pkt_valid = 1'b0;
  logic          pkt_ready;
  logic [31:0]   pkt_data = 32'd0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [WD-1:0] out_data;
  logic [7:0]    out_col;
  logic          out_last;
  logic [7:0]    row_cnt;
  logic [7:0]    drop_cnt;

  ifmap_row_rx #(
    .WIDTH_DATA(WD),
    .WIDTH_I   (WI),
    .NODE_ADDR (NODE),
    .DATA_TYPE (DT)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .pkt_valid(pkt_valid),
    .pkt_ready(pkt_ready),
    .pkt_data (pkt_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_col  (out_col),
    .out_last (out_last),
    .row_cnt  (row_cnt),
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model state.
  int m_val [WI];
  bit m_have[WI];
  int m_pix[$];
  int m_full;
  int m_beat;
  int m_rowcnt;
  int m_drop;
  bit m_accepted;
  bit rand_ready = 1'b0;

  function automatic void m_reset();
    for (int i = 0; i < WI; i++) begin
      m_val[i]  = 0;
      m_have[i] = 1'b0;
    end
    m_pix.delete();
    m_full     = 0;
    m_beat     = 0;
    m_rowcnt   = 0;
    m_drop     = 0;
    m_accepted = 1'b0;
  endfunction

  function automatic logic [31:0] mk(input logic rs, input logic [1:0] ty,
                                     input logic [7:0] dst, input logic [7:0] col,
                                     input logic [12:0] val);
    return {rs, ty, dst, col, val};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Compare every DUT output against what the model says the cycle should show.
  task automatic check_outputs();
    bit exp_valid;
    exp_valid = (m_full > 0);
    chk("pkt_ready", 32'(pkt_ready), 32'(m_full < 2));
    chk("out_valid", 32'(out_valid), 32'(exp_valid));
    chk("out_data",  32'(out_data),  exp_valid ? 32'(m_pix[0]) : 32'd0);
    chk("out_col",   32'(out_col),   exp_valid ? 32'(m_beat) : 32'd0);
    chk("out_last",  32'(out_last),  32'(exp_valid && (m_beat == WI - 1)));
    chk("row_cnt",   32'(row_cnt),   32'(m_rowcnt));
    chk("drop_cnt",  32'(drop_cnt),  32'(m_drop));
  endtask

  // Advance the model by one clock edge using the inputs the bench applied.
  task automatic model_edge();
    bit acc;
    bit rd;
    bit ok;
    bit all;
    int col;
    if (!rst_n) begin
      m_reset();
      return;
    end
    acc = pkt_valid && (m_full < 2);
    rd  = (m_full > 0) && out_ready;
    if (rd) begin
      void'(m_pix.pop_front());
      m_beat++;
      if (m_beat == WI) begin
        m_beat   = 0;
        m_full   = m_full - 1;
        m_rowcnt = (m_rowcnt + 1) % 256;
      end
    end
    if (acc) begin
      col = int'(pkt_data[20:13]);
      ok  = (pkt_data[31] == 1'b0) && (pkt_data[30:29] == DT) &&
            (pkt_data[28:21] == NODE) && (col < WI);
      if (ok) begin
        m_val[col]  = int'(pkt_data[12:0]);
        m_have[col] = 1'b1;
        all = 1'b1;
        for (int i = 0; i < WI; i++) if (!m_have[i]) all = 1'b0;
        if (all) begin
          for (int i = 0; i < WI; i++) begin
            m_pix.push_back(m_val[i]);
            m_have[i] = 1'b0;
          end
          m_full++;
        end
      end else if (m_drop < 255) begin
        m_drop++;
      end
    end
    m_accepted = acc;
  endtask

  task automatic tick();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_edge();
    #1;
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send(input logic [31:0] w);
    int n;
    pkt_valid = 1'b1;
    pkt_data  = w;
    n = 0;
    do begin
      tick();
      n++;
    end while (!m_accepted && n < 400);
    if (!m_accepted) begin
      checks++;
      failures++;
      $error("FAIL send_timeout got=%0d exp=%0d", n, 400);
    end
    pkt_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (m_full > 0 && n < 3000) begin
      tick();
      n++;
    end
    if (m_full > 0) begin
      checks++;
      failures++;
      $error("FAIL drain_timeout got=%0d exp=%0d", m_full, 0);
    end
    tick();
  endtask

  function automatic logic [31:0] junk();
    int kind;
    kind = int'($urandom_range(0, 3));
    case (kind)
      0:       return mk(1'b1, DT, NODE, 8'($urandom_range(0, WI - 1)), 13'($urandom));
      1:       return mk(1'b0, 2'b10, NODE, 8'($urandom_range(0, WI - 1)), 13'($urandom));
      2:       return mk(1'b0, DT, NODE + 8'd1, 8'($urandom_range(0, WI - 1)), 13'($urandom));
      default: return mk(1'b0, DT, NODE, 8'($urandom_range(WI, 255)), 13'($urandom));
    endcase
  endfunction

  // Random column order with occasional gaps, junk packets and duplicates.
  task automatic send_random_row();
    int perm[WI];
    int j;
    int t;
    for (int i = 0; i < WI; i++) perm[i] = i;
    for (int i = WI - 1; i > 0; i--) begin
      j = int'($urandom_range(0, i));
      t = perm[i];
      perm[i] = perm[j];
      perm[j] = t;
    end
    for (int i = 0; i < WI; i++) begin
      if ($urandom_range(0, 3) == 0) tick();
      if ($urandom_range(0, 4) == 0) send(junk());
      if ($urandom_range(0, 5) == 0) send(mk(1'b0, DT, NODE, 8'(perm[i]), 13'($urandom)));
      send(mk(1'b0, DT, NODE, 8'(perm[i]), 13'($urandom)));
    end
  endtask

  // Asynchronous reset: outputs must drop before any clock edge.
  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    pkt_valid = 1'b0;
    #1;
    chk({tag, "_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_ready"}, 32'(pkt_ready), 32'd1);
    chk({tag, "_data"},  32'(out_data),  32'd0);
    chk({tag, "_col"},   32'(out_col),   32'd0);
    chk({tag, "_last"},  32'(out_last),  32'd0);
    chk({tag, "_rows"},  32'(row_cnt),   32'd0);
    chk({tag, "_drops"}, 32'(drop_cnt),  32'd0);
    m_reset();
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    m_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    chk("reset_ready", 32'(pkt_ready), 32'd1);
    chk("reset_valid", 32'(out_valid), 32'd0);
    chk("reset_rows",  32'(row_cnt),   32'd0);
    rst_n = 1'b1;
    tick();

    // Step 1: in-order row, consumer always ready.
    out_ready = 1'b1;
    for (int c = 0; c < WI; c++) send(mk(1'b0, DT, NODE, 8'(c), 13'(100 + c)));
    chk("t1_first_valid", 32'(out_valid), 32'd1);
    chk("t1_first_data",  32'(out_data),  32'd100);
    drain();
    chk("t1_rows", 32'(row_cnt), 32'd1);

    // Step 2: reversed order, column 7 written twice.
    for (int c = WI - 1; c >= 0; c--) begin
      if (c == 7) begin
        send(mk(1'b0, DT, NODE, 8'd7, 13'd5));
        send(mk(1'b0, DT, NODE, 8'd7, 13'd9));
      end else begin
        send(mk(1'b0, DT, NODE, 8'(c), 13'(200 + c)));
      end
    end
    drain();
    chk("t2_rows",  32'(row_cnt),  32'd2);
    chk("t2_drops", 32'(drop_cnt), 32'd0);

    // Step 3: one of each discard reason interleaved with a valid row.
    for (int c = 0; c < WI; c++) begin
      send(mk(1'b0, DT, NODE, 8'(c), 13'(300 + c)));
      if (c == 3)  send(mk(1'b0, DT, NODE + 8'd1, 8'd3, 13'd1));
      if (c == 9)  send(mk(1'b0, 2'b10, NODE, 8'd9, 13'd2));
      if (c == 15) send(mk(1'b1, DT, NODE, 8'd15, 13'd3));
      if (c == 20) send(mk(1'b0, DT, NODE, 8'd25, 13'd4));
    end
    drain();
    chk("t3_drops", 32'(drop_cnt), 32'd4);
    chk("t3_rows",  32'(row_cnt),  32'd3);

    // Step 4: consumer stalled, three rows offered; the third is held upstream.
    out_ready = 1'b0;
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < WI; c++) send(mk(1'b0, DT, NODE, 8'(c), 13'(1000 + 100 * r + c)));
    pkt_valid = 1'b1;
    pkt_data  = mk(1'b0, DT, NODE, 8'd0, 13'd1200);
    repeat (4) tick();
    chk("t4_blocked", 32'(pkt_ready), 32'd0);
    chk("t4_stall_data", 32'(out_data), 32'd1000);
    out_ready = 1'b1;
    for (int c = 0; c < WI; c++) send(mk(1'b0, DT, NODE, 8'(c), 13'(1200 + c)));
    drain();
    chk("t4_rows", 32'(row_cnt), 32'd6);

    // Step 5: random rows with a randomly stalling consumer.
    rand_ready = 1'b1;
    for (int r = 0; r < 4; r++) send_random_row();
    drain();
    rand_ready = 1'b0;
    out_ready  = 1'b1;
    tick();
    chk("t5_rows", 32'(row_cnt), 32'd10);

    // Step 6: drop counter saturates.
    for (int i = 0; i < 260; i++) send(junk());
    tick();
    chk("t6_drop_sat", 32'(drop_cnt), 32'd255);

    // Step 7: reset with a partial row, then mid-stream, then a fresh row.
    for (int c = 0; c < 12; c++) send(mk(1'b0, DT, NODE, 8'(c), 13'(50 + c)));
    do_reset("rst_midrow");
    out_ready = 1'b0;
    for (int c = 0; c < WI; c++) send(mk(1'b0, DT, NODE, 8'(c), 13'(700 + c)));
    out_ready = 1'b1;
    repeat (3) tick();
    do_reset("rst_midstream");
    for (int c = 0; c < WI; c++) send(mk(1'b0, DT, NODE, 8'(WI - 1 - c), 13'(900 + c)));
    drain();
    chk("t7_rows", 32'(row_cnt), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
